// File: rtl/branch_predictor_bht.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_bht
// Purpose  : PC-indexed saturating-counter direction predictor at IF, plus an
//            ID-stage BEQ/BNE resolver with forwarding, flush and training.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor_bht #(
    parameter int         ENTRIES  = 64,
    parameter int         CTR_BITS = 2,
    parameter int         DATA_W   = 32,
    parameter int         PC_W     = 32,
    parameter logic [5:0] BEQ      = 6'h04,
    parameter logic [5:0] BNE      = 6'h05
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic [PC_W-1:0]   if_pc,
    input  logic [5:0]        if_op,
    output logic              pred_taken,
    input  logic              id_valid,
    input  logic [PC_W-1:0]   id_pc,
    input  logic [5:0]        id_op,
    input  logic [1:0]        fa,
    input  logic [1:0]        fb,
    input  logic [DATA_W-1:0] reg_out1,
    input  logic [DATA_W-1:0] reg_out2,
    input  logic [DATA_W-1:0] memwb_value,
    input  logic [DATA_W-1:0] exmem_aluout,
    output logic              takebranch,
    output logic              mispredict,
    output logic [31:0]       branch_count,
    output logic [31:0]       mispredict_count
);

    localparam int                  IDX_W      = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] c_ctr_init = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] c_ctr_max  = {CTR_BITS{1'b1}};

    logic [CTR_BITS-1:0] r_ctr [ENTRIES];
    logic                r_id_pred;
    logic [31:0]         r_branch_count;
    logic [31:0]         r_mispredict_count;

    logic [IDX_W-1:0]    w_if_idx;
    logic [IDX_W-1:0]    w_id_idx;
    logic                w_if_br;
    logic                w_id_br;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic                w_train;
    logic [CTR_BITS-1:0] w_ctr_cur;
    logic [CTR_BITS-1:0] w_ctr_next;
    logic                w_unused_pc;

    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] rf,
        input logic [DATA_W-1:0] mw,
        input logic [DATA_W-1:0] ex
    );
        case (sel)
            2'b00:   return rf;
            2'b01:   return mw;
            default: return ex;
        endcase
    endfunction

    // Word-aligned PCs: drop the byte-offset bits, no tag is kept.
    assign w_if_idx    = if_pc[IDX_W+1:2];
    assign w_id_idx    = id_pc[IDX_W+1:2];
    assign w_unused_pc = ^{if_pc, id_pc};

    assign w_if_br    = (if_op == BEQ) || (if_op == BNE);
    assign w_id_br    = id_valid && ((id_op == BEQ) || (id_op == BNE));
    assign pred_taken = w_if_br && r_ctr[w_if_idx][CTR_BITS-1];

    assign w_a = fwd_sel(fa, reg_out1, memwb_value, exmem_aluout);
    assign w_b = fwd_sel(fb, reg_out2, memwb_value, exmem_aluout);

    assign takebranch = w_id_br && (((id_op == BEQ) && (w_a == w_b)) ||
                                    ((id_op == BNE) && (w_a != w_b)));
    assign mispredict = w_id_br && !stall && (takebranch != r_id_pred);
    assign w_train    = w_id_br && !stall;

    assign w_ctr_cur = r_ctr[w_id_idx];

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (takebranch) begin
            if (w_ctr_cur != c_ctr_max) w_ctr_next = w_ctr_cur + CTR_BITS'(1);
        end else begin
            if (w_ctr_cur != '0) w_ctr_next = w_ctr_cur - CTR_BITS'(1);
        end
    end

    // IF reads the pre-edge value on a same-index collision; no bypass.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= c_ctr_init;
        end else if (w_train) begin
            r_ctr[w_id_idx] <= w_ctr_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_id_pred          <= 1'b0;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (!stall) begin
            r_id_pred <= mispredict ? 1'b0 : pred_taken;
            if (w_train) begin
                r_branch_count <= r_branch_count + 32'd1;
                if (mispredict) r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_bht.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor_bht
// Purpose  : Directed vector table plus randomized run against a counter-array
//            model for branch_predictor_bht (64-entry and 4-entry instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_bht;

    localparam logic [5:0] c_beq = 6'h04;
    localparam logic [5:0] c_bne = 6'h05;

    logic        clock = 1'b0;
    logic        reset, stall, id_valid;
    logic [31:0] if_pc, id_pc;
    logic [5:0]  if_op, id_op;
    logic [1:0]  fa, fb;
    logic [31:0] reg_out1, reg_out2, memwb_value, exmem_aluout;

    logic        pred_taken, takebranch, mispredict;
    logic [31:0] branch_count, mispredict_count;
    logic        pred4, tb4, mis4;
    logic [31:0] bc4, mc4;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clock = ~clock;

    branch_predictor_bht dut (
        .clock(clock), .reset(reset), .stall(stall),
        .if_pc(if_pc), .if_op(if_op), .pred_taken(pred_taken),
        .id_valid(id_valid), .id_pc(id_pc), .id_op(id_op),
        .fa(fa), .fb(fb), .reg_out1(reg_out1), .reg_out2(reg_out2),
        .memwb_value(memwb_value), .exmem_aluout(exmem_aluout),
        .takebranch(takebranch), .mispredict(mispredict),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    branch_predictor_bht #(.ENTRIES(4)) dut4 (
        .clock(clock), .reset(reset), .stall(stall),
        .if_pc(if_pc), .if_op(if_op), .pred_taken(pred4),
        .id_valid(id_valid), .id_pc(id_pc), .id_op(id_op),
        .fa(fa), .fb(fb), .reg_out1(reg_out1), .reg_out2(reg_out2),
        .memwb_value(memwb_value), .exmem_aluout(exmem_aluout),
        .takebranch(tb4), .mispredict(mis4),
        .branch_count(bc4), .mispredict_count(mc4)
    );

    typedef struct {
        logic        rst, stl;
        logic [31:0] ipc;
        logic [5:0]  iop;
        logic        idv;
        logic [31:0] dpc;
        logic [5:0]  dop;
        logic [1:0]  sa, sb;
        logic [31:0] r1, r2, mw, ex;
        logic        use4;
        logic        e_pred, e_tb, e_mis;
        int          e_bc, e_mc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic rst, input logic stl, input logic [31:0] ipc, input logic [5:0] iop,
        input logic idv, input logic [31:0] dpc, input logic [5:0] dop,
        input logic [1:0] sa, input logic [1:0] sb,
        input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] mw, input logic [31:0] ex,
        input logic use4, input logic e_pred, input logic e_tb, input logic e_mis,
        input int e_bc, input int e_mc
    );
        vec_t v;
        v.rst = rst; v.stl = stl; v.ipc = ipc; v.iop = iop; v.idv = idv; v.dpc = dpc;
        v.dop = dop; v.sa = sa; v.sb = sb; v.r1 = r1; v.r2 = r2; v.mw = mw; v.ex = ex;
        v.use4 = use4; v.e_pred = e_pred; v.e_tb = e_tb; v.e_mis = e_mis;
        v.e_bc = e_bc; v.e_mc = e_mc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic rst, input logic stl, input logic [31:0] ipc, input logic [5:0] iop,
                         input logic idv, input logic [31:0] dpc, input logic [5:0] dop,
                         input logic [1:0] sa, input logic [1:0] sb,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] mw, input logic [31:0] ex);
        reset = rst; stall = stl; if_pc = ipc; if_op = iop; id_valid = idv; id_pc = dpc;
        id_op = dop; fa = sa; fb = sb; reg_out1 = r1; reg_out2 = r2;
        memwb_value = mw; exmem_aluout = ex;
    endtask

    function automatic bit is_br(input logic [5:0] op);
        return (op == c_beq) || (op == c_bne);
    endfunction

    // Reference model: counters as plain integers in 0..3.
    int          mctr [64];
    bit          m_idpred;
    int unsigned m_bc, m_mc;

    initial begin
        // reset; BEQ@0x40 learns taken; saturation run; not-taken decay
        vq.push_back(mk(1,0, 0,0,       0,0,0,        0,0, 0,0,0,0, 0, 0,0,0, -1,-1));
        vq.push_back(mk(0,0, 'h40,c_beq, 0,0,0,       0,0, 0,0,0,0, 0, 0,0,0, 0,0));
        vq.push_back(mk(0,0, 'h40,c_beq, 1,'h40,c_beq, 0,0, 5,5,0,0, 0, 0,1,1, 0,0));
        vq.push_back(mk(0,0, 'h40,c_beq, 0,0,0,       0,0, 0,0,0,0, 0, 1,0,0, 1,1));
        for (int k = 0; k < 5; k++)
            vq.push_back(mk(0,0, 'h40,c_beq, 1,'h40,c_beq, 0,0, 5,5,0,0, 0, 1,1,0, 1+k,1));
        vq.push_back(mk(0,0, 'h40,c_beq, 1,'h40,c_beq, 0,0, 5,6,0,0, 0, 1,0,1, 6,1));
        vq.push_back(mk(0,0, 'h40,c_beq, 0,0,0,       0,0, 0,0,0,0, 0, 1,0,0, 7,2));
        vq.push_back(mk(0,0, 'h40,c_beq, 1,'h40,c_beq, 0,0, 5,6,0,0, 0, 1,0,1, 7,2));
        vq.push_back(mk(0,0, 'h40,c_beq, 0,0,0,       0,0, 0,0,0,0, 0, 0,0,0, 8,3));
        // BNE forwarding selects
        vq.push_back(mk(0,0, 0,0, 1,'h80,c_bne, 2,0, 7,7,0,9, 0, 0,1,1, 8,3));
        vq.push_back(mk(0,0, 0,0, 1,'h80,c_bne, 3,0, 7,7,0,9, 0, 0,1,1, 9,4));
        vq.push_back(mk(0,0, 0,0, 1,'h80,c_bne, 1,0, 7,7,7,9, 0, 0,0,0, 10,5));
        vq.push_back(mk(0,0, 0,0, 1,'h80,c_bne, 0,2, 7,0,7,7, 0, 0,0,0, 11,5));
        // non-branch in ID, then a bubble carrying a branch opcode
        vq.push_back(mk(0,0, 'h40,c_beq, 1,'h40,6'h23, 0,0, 5,5,0,0, 0, 0,0,0, 12,5));
        vq.push_back(mk(0,0, 'h40,c_beq, 0,'h40,c_beq, 0,0, 5,5,0,0, 0, 0,0,0, 12,5));
        vq.push_back(mk(0,0, 'h40,c_beq, 0,0,0,       0,0, 0,0,0,0, 0, 0,0,0, 12,5));
        // three stalled cycles then release: exactly one update
        for (int k = 0; k < 3; k++)
            vq.push_back(mk(0,1, 'h40,c_beq, 1,'h40,c_beq, 0,0, 5,5,0,0, 0, 0,1,0, 12,5));
        vq.push_back(mk(0,0, 'h40,c_beq, 1,'h40,c_beq, 0,0, 5,5,0,0, 0, 0,1,1, 12,5));
        vq.push_back(mk(0,0, 'h40,c_beq, 0,0,0,       0,0, 0,0,0,0, 0, 1,0,0, 13,6));
        vq.push_back(mk(0,0, 0,0,       1,'h40,c_beq, 0,0, 5,6,0,0, 0, 0,0,1, 13,6));
        vq.push_back(mk(0,0, 'h40,c_beq, 0,0,0,       0,0, 0,0,0,0, 0, 0,0,0, 14,7));
        // reset with a taken branch in ID: must not train or count
        vq.push_back(mk(1,0, 0,0,       1,'h40,c_beq, 0,0, 5,5,0,0, 0, 0,1,1, 14,7));
        vq.push_back(mk(0,0, 'h40,c_beq, 0,0,0,       0,0, 0,0,0,0, 0, 0,0,0, 0,0));
        // 4-entry instance: 0x10/0x20/0x30 alias to index 0
        vq.push_back(mk(1,0, 0,0,       0,0,0,        0,0, 0,0,0,0, 1, 0,0,0, -1,-1));
        vq.push_back(mk(0,0, 'h10,c_beq, 0,0,0,       0,0, 0,0,0,0, 1, 0,0,0, 0,0));
        vq.push_back(mk(0,0, 'h20,c_beq, 1,'h10,c_beq, 0,0, 5,5,0,0, 1, 0,1,1, 0,0));
        vq.push_back(mk(0,0, 'h20,c_beq, 0,0,0,       0,0, 0,0,0,0, 1, 1,0,0, 1,1));
        vq.push_back(mk(0,0, 'h30,c_beq, 0,0,0,       0,0, 0,0,0,0, 1, 1,0,0, 1,1));

        drive(1,0,0,0,0,0,0,0,0,0,0,0,0);
        #1;
        foreach (vq[i]) begin
            vec_t v;
            v = vq[i];
            drive(v.rst, v.stl, v.ipc, v.iop, v.idv, v.dpc, v.dop, v.sa, v.sb,
                  v.r1, v.r2, v.mw, v.ex);
            #2;
            chk($sformatf("v%0d pred", i), v.use4 ? pred4 : pred_taken, v.e_pred);
            chk($sformatf("v%0d takebranch", i), v.use4 ? tb4 : takebranch, v.e_tb);
            chk($sformatf("v%0d mispredict", i), v.use4 ? mis4 : mispredict, v.e_mis);
            if (v.e_bc >= 0) begin
                chk($sformatf("v%0d branch_count", i), v.use4 ? bc4 : branch_count, v.e_bc);
                chk($sformatf("v%0d mispredict_count", i), v.use4 ? mc4 : mispredict_count, v.e_mc);
            end
            @(posedge clock); #1;
        end

        // randomized run; cycle 0 forces reset so the model starts aligned
        for (int n = 0; n < 600; n++) begin
            logic        r_rst, r_stl, r_idv;
            logic [31:0] r_ipc, r_dpc, r_r1, r_r2, r_mw, r_ex, a, b;
            logic [5:0]  r_iop, r_dop;
            logic [1:0]  r_fa, r_fb;
            logic [5:0]  ops [4];
            bit          e_pred, e_tb, e_mis, idbr;
            int          ii, di;
            ops[0] = c_beq; ops[1] = c_bne; ops[2] = 6'h23; ops[3] = 6'h00;
            r_rst = (n == 0) || ($urandom_range(0, 59) == 0);
            r_stl = ($urandom_range(0, 3) == 0);
            r_idv = ($urandom_range(0, 3) != 0);
            r_ipc = ($urandom & 32'hFFFF_FF00) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            r_dpc = ($urandom & 32'hFFFF_FF00) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            r_iop = ops[$urandom_range(0, 3)];
            r_dop = ops[$urandom_range(0, 3)];
            r_fa  = 2'($urandom_range(0, 3));
            r_fb  = 2'($urandom_range(0, 3));
            r_r1  = $urandom_range(0, 2); r_r2 = $urandom_range(0, 2);
            r_mw  = $urandom_range(0, 2); r_ex = $urandom_range(0, 2);
            drive(r_rst, r_stl, r_ipc, r_iop, r_idv, r_dpc, r_dop, r_fa, r_fb,
                  r_r1, r_r2, r_mw, r_ex);
            #2;
            ii     = (r_ipc / 4) % 64;
            di     = (r_dpc / 4) % 64;
            a      = (r_fa == 0) ? r_r1 : (r_fa == 1) ? r_mw : r_ex;
            b      = (r_fb == 0) ? r_r2 : (r_fb == 1) ? r_mw : r_ex;
            idbr   = r_idv && is_br(r_dop);
            e_pred = is_br(r_iop) && (mctr[ii] >= 2);
            e_tb   = idbr && ((r_dop == c_beq) ? (a == b) : (a != b));
            e_mis  = idbr && !r_stl && (e_tb != m_idpred);
            if (n != 0) begin
                chk($sformatf("r%0d pred", n), pred_taken, e_pred);
                chk($sformatf("r%0d takebranch", n), takebranch, e_tb);
                chk($sformatf("r%0d mispredict", n), mispredict, e_mis);
                chk($sformatf("r%0d branch_count", n), branch_count, m_bc);
                chk($sformatf("r%0d mispredict_count", n), mispredict_count, m_mc);
            end
            @(posedge clock); #1;
            if (r_rst) begin
                foreach (mctr[k]) mctr[k] = 1;
                m_idpred = 0; m_bc = 0; m_mc = 0;
            end else if (!r_stl) begin
                if (idbr) begin
                    mctr[di] = e_tb ? ((mctr[di] < 3) ? mctr[di] + 1 : 3)
                                    : ((mctr[di] > 0) ? mctr[di] - 1 : 0);
                    m_bc++;
                    if (e_mis) m_mc++;
                end
                m_idpred = e_mis ? 0 : e_pred;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predictor_bht.md
# branch_predictor_bht

Parametrised dynamic branch predictor and ID-stage resolver for the mips pipeline. Predicts BEQ/BNE direction at IF from a table of saturating counters indexed by PC. Resolves the branch in ID using the forwarded operand muxes. Flags mispredictions and trains the table. Replaces the static, BEQ-only take-branch unit; all forwarded values arrive as ports, with no hierarchical references.

## Interface
Parameters:
- ENTRIES, 64, number of counters; power of two, at least 2; IDX_W = log2(ENTRIES)
- CTR_BITS, 2, counter width, at least 1
- DATA_W, 32, operand width
- PC_W, 32, PC width; must be at least IDX_W+2
- BEQ, 6'h04, opcode of branch-if-equal
- BNE, 6'h05, opcode of branch-if-not-equal

Ports:
- clock  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  synchronous reset, active-high
- stall  in  1  IF/ID hold; blocks the ID prediction register, table training and statistics
- if_pc  in  PC_W  PC of the instruction being fetched
- if_op  in  6  opcode of the fetched instruction
- pred_taken  out  1  IF prediction (combinational)
- id_valid  in  1  ID stage holds a real instruction (not a bubble)
- id_pc  in  PC_W  PC of the ID instruction
- id_op  in  6  opcode of the ID instruction
- fa, fb  in  2  forward selects: 00 = register file, 01 = MEM/WB value, 10 or 11 = EX/MEM ALU out
- reg_out1, reg_out2  in  DATA_W  register file read data
- memwb_value  in  DATA_W  MEM/WB writeback value
- exmem_aluout  in  DATA_W  EX/MEM ALU result
- takebranch  out  1  resolved direction of the ID branch
- mispredict  out  1  ID branch resolved against its prediction; IF/ID flush request
- branch_count  out  32  resolved branches since reset
- mispredict_count  out  32  mispredictions since reset

## Operation
- Index is pc[IDX_W+1:2]. Tag-free, so aliasing is permitted.
- Counter table:
  - ENTRIES x CTR_BITS flops.
  - Reset value of every entry is 2^(CTR_BITS-1)-1, i.e. weakly not-taken.
  - Counter MSB = 1 means predict taken.
- pred_taken = (if_op==BEQ or if_op==BNE) and MSB of counter[idx(if_pc)]. It is 0 for all other opcodes.
- id_pred register:
  - Captures pred_taken at each edge where stall=0.
  - Cleared to 0 on an edge where mispredict=1, because the fetched instruction is flushed.
  - Holds its value while stall=1.
- Operands:
  - a = fa mux over {reg_out1, memwb_value, exmem_aluout}.
  - b = fb mux over {reg_out2, memwb_value, exmem_aluout}.
  - Selects 10 and 11 are identical.
- id_branch = id_valid and (id_op==BEQ or id_op==BNE).
- takebranch = id_branch and ((id_op==BEQ and a==b) or (id_op==BNE and a!=b)).
- mispredict = id_branch and !stall and (takebranch != id_pred).
- Training: on each edge with id_branch=1 and stall=0, update counter[idx(id_pc)]:
  - taken: increment, saturating at 2^CTR_BITS-1
  - not taken: decrement, saturating at 0
- Statistics: on the same qualifying edge, branch_count increments; mispredict_count increments if mispredict=1. Both counters wrap modulo 2^32.
- Same-entry conflict: if the IF read and the ID update target the same index in one cycle, IF sees the old value. There is no bypass.
- Reset priority: reset=1 overrides training, statistics and id_pred.

## Timing
- pred_taken, takebranch and mispredict are combinational, with zero-cycle latency from their inputs.
- id_pred is valid one cycle after the branch was at IF.
- A counter update is visible to pred_taken on the cycle after the training edge.
- Reset values:
  - pred_taken = 0 when the table is at its reset state, since the MSB is 0.
  - takebranch = 0 and mispredict = 0 whenever id_valid=0.
  - id_pred = 0.
  - branch_count = 0 and mispredict_count = 0.
- Reset lasts 1 cycle minimum. The table is fully reinitialised on the first reset edge.
- Reset mid-stream abandons the ID branch: no training occurs and no counts change.
- During stall=1, mispredict is forced to 0 and nothing trains. The branch is resolved and trained exactly once, on the first edge with stall=0.

## Test plan
- Reset, then BEQ at PC 0x40 with reg_out1=reg_out2=5, fa=fb=00:
  - pred_taken=0 at IF.
  - At ID: takebranch=1, mispredict=1.
  - Next cycle: counter[16] reads 2 and pred_taken=1 for PC 0x40.
  - branch_count=1, mispredict_count=1.
- Saturation: resolve BEQ at PC 0x40 taken 5 times, then not taken once.
  - Counter holds at 3 during the taken run.
  - After the not-taken branch it reads 2, and pred_taken stays 1.
- Forwarding with BNE:
  - reg_out1=reg_out2=7, exmem_aluout=9, fa=10 → takebranch=1.
  - Same values with fa=11 → takebranch=1.
  - Same values with fa=01 and memwb_value=7 → takebranch=0.
- Stall: hold stall=1 for 3 cycles with a taken BEQ in ID.
  - mispredict=0 and the counters are unchanged during the stall.
  - On release, exactly one training update occurs and branch_count advances by 1.
- Aliasing and conflict with ENTRIES=4:
  - PCs 0x10 and 0x20 share index 0.
  - An ID update of index 0 while IF reads PC 0x20 returns the pre-update prediction.
- Non-branch opcodes (id_op=0x23) and id_valid=0 bubbles: takebranch=0, no training, counts unchanged.
